// File: rtl/rotsq_ctrl.sv
// rotsq_ctrl -- position sequencer for the rotating-square display.
//
// The square walks a loop of 8 slots: the upper half of digits 3..0
// (pos 0..3), then the lower half of digits 0..3 (pos 4..7). The position
// advances either at a prescaled rate (en=1) or once per single-step
// handshake (en=0).
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   synchronous, active-low
//   en        in   1 = free-run rotation, 0 = hold / single-step mode
//   cw        in   direction: 1 = pos+1 mod 8, 0 = pos-1 mod 8
//   step_req  in   single-step request (level, 4-phase handshake)
//   step_ack  out  single-step acknowledge
//   pos       out  current square position 0..7 (registered)
//   top       out  1 = upper square, 0 = lower square
//   anode     out  active-low digit enable, one-hot-low
//   tick      out  prescaler terminal pulse (observation only)
module rotsq_ctrl #(
    parameter int unsigned           TICK_W   = 24,
    parameter logic [TICK_W-1:0]     TICK_MAX = 24'd12_499_999
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic       cw,
    input  logic       step_req,
    output logic       step_ack,
    output logic [2:0] pos,
    output logic       top,
    output logic [3:0] anode,
    output logic       tick
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_ACK,
        S_REL
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [TICK_W-1:0] cnt;
    logic [TICK_W-1:0] cnt_next;
    logic [2:0]        pos_next;
    logic [2:0]        pos_step;
    logic              at_max;

    // Candidate next position; 3-bit arithmetic gives the 7->0 / 0->7 wrap.
    assign pos_step = cw ? (pos + 3'd1) : (pos - 3'd1);
    assign at_max   = (cnt == TICK_MAX);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            pos   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            pos   <= pos_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pos_next   = pos;
        case (state)
            S_IDLE: begin
                // en wins over a pending step request.
                if (en) begin
                    state_next = S_RUN;
                    cnt_next   = '0;
                end else if (step_req) begin
                    pos_next   = pos_step;
                    state_next = S_ACK;
                end
            end
            S_RUN: begin
                // Dropping en freezes everything on that edge, even at terminal count.
                if (!en) begin
                    state_next = S_IDLE;
                end else if (at_max) begin
                    cnt_next = '0;
                    pos_next = pos_step;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_ACK: begin
                state_next = step_req ? S_REL : S_IDLE;
            end
            S_REL: begin
                if (!step_req) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign step_ack = (state == S_ACK) || (state == S_REL);
    assign tick     = (state == S_RUN) && en && at_max;

    // Upper half runs digit 3..0, lower half runs digit 0..3.
    always_comb begin
        top   = ~pos[2];
        anode = 4'b1111;
        case (pos)
            3'd0:    anode = 4'b0111;
            3'd1:    anode = 4'b1011;
            3'd2:    anode = 4'b1101;
            3'd3:    anode = 4'b1110;
            3'd4:    anode = 4'b1110;
            3'd5:    anode = 4'b1101;
            3'd6:    anode = 4'b1011;
            3'd7:    anode = 4'b0111;
            default: anode = 4'b1111;
        endcase
    end

endmodule

// File: doc/rotsq_ctrl.md
# rotsq_ctrl

Position sequencer for the rotating-square display (exercise 4.7.3). Holds the square's position around the loop of 8 slots: upper half of digits 3→0, then lower half of digits 0→3. Advances the position at a programmable prescaled rate or by single-step handshake, and drives the active-low anode select plus an upper/lower flag to the segment datapath.

## Interface
- `TICK_W`, 24: prescaler counter width.
- `TICK_MAX`, 24'd12_499_999: terminal count; advance period = TICK_MAX+1 clock cycles (4 Hz at 50 MHz). Must fit in TICK_W bits.
- `clock` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-low; one clock domain only.
- `en` in 1: 1 = free-run rotation, 0 = hold / single-step mode.
- `cw` in 1: direction; 1 = pos+1 mod 8, 0 = pos−1 mod 8.
- `step_req` in 1: single-step request, level, 4-phase handshake; honoured only when `en`=0.
- `step_ack` out 1: single-step acknowledge.
- `pos` out 3: current square position 0..7, registered.
- `top` out 1: 1 = upper square (segments a,b,f,g), 0 = lower square (c,d,e,g).
- `anode` out 4: active-low digit enable, one-hot-low.
- `tick` out 1: prescaler terminal pulse, one cycle wide; for observation only.

## Operation
- FSM states:
  - S_IDLE: position frozen.
  - S_RUN: prescaled advance.
  - S_ACK: step done, `step_ack`=1.
  - S_REL: wait for `step_req` release.
- S_IDLE: `en`=1 → S_RUN with cnt←0. Else `step_req`=1 → advance pos once, → S_ACK. `en` has priority over `step_req`.
- S_RUN: cnt increments each cycle. When cnt==TICK_MAX: cnt←0, pos advances per `cw`. `en`=0 → S_IDLE; cnt is not advanced and there is no pos change on that edge. `step_req` is ignored; `step_ack` stays 0.
- S_ACK: `step_ack`=1. `step_req`=0 → S_IDLE. Otherwise → S_REL.
- S_REL: `step_ack`=1 until `step_req`=0, then → S_IDLE with `step_ack`=0. Exactly one advance per request, regardless of hold length. `en` is ignored until the handshake completes; the FSM then goes S_IDLE→S_RUN on the next edge.
- Position map, combinational from registered `pos`:
  - 0..3: top=1, digit 3,2,1,0 → anode 0111, 1011, 1101, 1110.
  - 4..7: top=0, digit 0,1,2,3 → anode 1110, 1101, 1011, 0111.
- Wrap-around: cw 7→0; ccw 0→7. 3-bit modular arithmetic, no saturation.
- `cw` is sampled only at the advancing edge. A change mid-period affects the next advance only.
- `tick` = (state==S_RUN) & `en` & (cnt==TICK_MAX).

## Timing
- Reset value (`reset`=0 at a clock edge): state S_IDLE, cnt=0, pos=0, step_ack=0, tick=0, top=1, anode=4'b0111. `reset` overrides all other inputs, including mid-handshake and mid-period.
- Latency:
  - `en` rising sampled at edge E → S_RUN at E. First advance at edge E+TICK_MAX+1, then every TICK_MAX+1 cycles.
  - `en` falling sampled at an edge → no advance at that edge, even if cnt==TICK_MAX.
  - Re-enabling restarts a full period (cnt cleared).
  - `step_req` sampled high in S_IDLE at edge E → pos updated and `step_ack`=1 from E. `step_ack` deasserts at the edge that samples `step_req`=0.
- `anode` and `top` change in the same cycle as `pos`, with no added latency.
- After reset release with `step_req` already high, the next edge performs one step.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with en=1, step_req=1 → pos=0, anode=0111, top=1, step_ack=0, tick=0 throughout.
- CW run, TICK_MAX=3, en=1, cw=1 → pos 1 at 4 cycles after en is sampled, then +1 every 4 cycles. Anode sequence 1011, 1101, 1110, 1110(top=0), 1101, 1011, 0111, then pos 0 → 0111 top=1. `tick` is high on the cycle before each advance.
- CCW wrap from pos=0, cw=0, TICK_MAX=3 → pos 7 (anode 0111, top=0), then 6 (anode 1011). Flipping cw to 1 mid-period → next advance goes 6→7.
- Single step: en=0, step_req=1 held 10 cycles → pos increments exactly once, step_ack=1 for 10 cycles. Drop step_req → step_ack=0 one edge later. A second request advances again.
- Pause: en=1, drop en when cnt==2 → pos frozen. Re-assert en → next advance exactly 4 cycles after en is sampled. en dropped on the tick cycle → no advance.
- Reset mid-run: pos=5, cnt=2, assert reset for 1 edge → pos=0, anode=0111. Release with en=1 → first advance 4 cycles after the edge that samples reset=1 and en=1.
